// File: rtl/pe_pkg.sv
// Shared control encodings and default widths for the weight-stationary PE.
package pe_pkg;

  localparam logic [1:0] CTRL_IDLE    = 2'b00;
  localparam logic [1:0] CTRL_COMPUTE = 2'b01;
  localparam logic [1:0] CTRL_SWAP    = 2'b10;
  localparam logic [1:0] CTRL_CLEAR   = 2'b11;

  localparam int PE_WORD_WIDTH = 8;
  localparam int PE_ACC_WIDTH  = 32;

endpackage

// File: rtl/pe_mac.sv
// Combinational multiply-accumulate for pe_ws_dbuf. Wraps modulo 2^ACC_WIDTH by
// default; with PE_WS_SATURATE_EN defined it clamps and flags overflow.
module pe_mac
  import pe_pkg::*;
#(
  parameter int WORD_WIDTH = PE_WORD_WIDTH,
  parameter int ACC_WIDTH  = PE_ACC_WIDTH,
  parameter int SIGNED     = 1
) (
  input  logic [WORD_WIDTH-1:0] w,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0]  ps,
  output logic [ACC_WIDTH-1:0]  sum,
  output logic                  ovf
);

  localparam int PW = 2 * WORD_WIDTH;
  localparam bit SX = (SIGNED != 0);

  logic signed [PW-1:0]        w_x;
  logic signed [PW-1:0]        a_x;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_x;

  // Operands widened to the product width so the low PW bits are exact for
  // both signed and unsigned operation.
  always_comb begin
    w_x    = {{WORD_WIDTH{SX & w[WORD_WIDTH-1]}}, w};
    a_x    = {{WORD_WIDTH{SX & a[WORD_WIDTH-1]}}, a};
    prod   = w_x * a_x;
    prod_x = {{(ACC_WIDTH-PW){SX & prod[PW-1]}}, prod};
  end

`ifdef PE_WS_SATURATE_EN
  logic [ACC_WIDTH:0] raw;
  logic               ovf_det;

  function automatic logic [ACC_WIDTH-1:0] sat_limit(input logic neg);
    if (!SX) return '1;
    return neg ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  endfunction

  always_comb begin
    raw = {1'b0, ps} + {1'b0, prod_x};
    if (SX) ovf_det = (ps[ACC_WIDTH-1] == prod_x[ACC_WIDTH-1]) &&
                      (raw[ACC_WIDTH-1] != ps[ACC_WIDTH-1]);
    else    ovf_det = raw[ACC_WIDTH];
    sum = ovf_det ? sat_limit(ps[ACC_WIDTH-1]) : raw[ACC_WIDTH-1:0];
    ovf = ovf_det;
  end
`else
  always_comb begin
    sum = ps + prod_x;
    ovf = 1'b0;
  end
`endif

endmodule

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary systolic PE with double-buffered (active/shadow) weight.
// Optional saturating accumulate and sticky overflow via PE_WS_SATURATE_EN.
module pe_ws_dbuf
  import pe_pkg::*;
#(
  parameter int WORD_WIDTH = PE_WORD_WIDTH,
  parameter int ACC_WIDTH  = PE_ACC_WIDTH,
  parameter int SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            control_in,
  output logic [1:0]            control_out,
  input  logic [WORD_WIDTH-1:0] a_in,
  input  logic                  a_valid_in,
  output logic [WORD_WIDTH-1:0] a_out,
  output logic                  a_valid_out,
  input  logic [WORD_WIDTH-1:0] w_in,
  input  logic                  w_load_in,
  output logic [WORD_WIDTH-1:0] w_out,
  output logic                  w_load_out,
  input  logic [ACC_WIDTH-1:0]  ps_in,
  input  logic                  ps_valid_in,
  output logic [ACC_WIDTH-1:0]  ps_out,
  output logic                  ps_valid_out,
  output logic                  shadow_valid,
  output logic                  ovf_out
);

  logic [WORD_WIDTH-1:0] active_w;
  logic [WORD_WIDTH-1:0] shadow_w;
  logic                  shadow_vld;
  logic [WORD_WIDTH-1:0] a_p1;
  logic [ACC_WIDTH-1:0]  ps_p1;
  logic                  a_vld_p1;
  logic                  ps_vld_p1;
  logic [1:0]            ctrl_p1;
  logic                  w_load_p1;
  logic                  ovf_p1;
  logic [ACC_WIDTH-1:0]  mac_sum;
  logic                  mac_ovf;

  pe_mac #(
    .WORD_WIDTH(WORD_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .SIGNED    (SIGNED)
  ) u_mac (
    .w  (active_w),
    .a  (a_in),
    .ps (ps_in),
    .sum(mac_sum),
    .ovf(mac_ovf)
  );

  // Stage p0 -> p1: every output of the PE is a register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_w   <= '0;
      shadow_w   <= '0;
      shadow_vld <= 1'b0;
      a_p1       <= '0;
      ps_p1      <= '0;
      a_vld_p1   <= 1'b0;
      ps_vld_p1  <= 1'b0;
      ctrl_p1    <= CTRL_IDLE;
      w_load_p1  <= 1'b0;
      ovf_p1     <= 1'b0;
    end else begin
      ctrl_p1   <= control_in;
      w_load_p1 <= w_load_in;
      if (w_load_in) begin
        shadow_w   <= w_in;
        shadow_vld <= 1'b1;
      end
      case (control_in)
        CTRL_COMPUTE: begin
          a_vld_p1  <= a_valid_in;
          ps_vld_p1 <= a_valid_in & ps_valid_in;
          if (a_valid_in) begin
            a_p1   <= a_in;
            ps_p1  <= mac_sum;
            ovf_p1 <= ovf_p1 | mac_ovf;
          end
        end
        CTRL_SWAP: begin
          a_vld_p1  <= 1'b0;
          ps_vld_p1 <= 1'b0;
          if (shadow_vld) active_w <= shadow_w;
          // A load in the same cycle refills the shadow, so it stays pending.
          shadow_vld <= w_load_in;
        end
        CTRL_CLEAR: begin
          active_w  <= '0;
          a_p1      <= '0;
          ps_p1     <= '0;
          a_vld_p1  <= 1'b0;
          ps_vld_p1 <= 1'b0;
          ovf_p1    <= 1'b0;
          if (!w_load_in) begin
            shadow_w   <= '0;
            shadow_vld <= 1'b0;
          end
        end
        default: begin
          a_vld_p1  <= 1'b0;
          ps_vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign control_out  = ctrl_p1;
  assign a_out        = a_p1;
  assign a_valid_out  = a_vld_p1;
  assign w_out        = shadow_w;
  assign w_load_out   = w_load_p1;
  assign ps_out       = ps_p1;
  assign ps_valid_out = ps_vld_p1;
  assign shadow_valid = shadow_vld;
  assign ovf_out      = ovf_p1;

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Randomized and directed bench for pe_ws_dbuf: a signed and an unsigned
// instance share stimulus and are compared against an arithmetic reference.
module tb_pe_ws_dbuf;

  localparam logic [1:0] C_IDLE = 2'b00;
  localparam logic [1:0] C_COMP = 2'b01;
  localparam logic [1:0] C_SWAP = 2'b10;
  localparam logic [1:0] C_CLR  = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  control_in = C_IDLE;
  logic [7:0]  a_in = '0;
  logic        a_valid_in = 1'b0;
  logic [7:0]  w_in = '0;
  logic        w_load_in = 1'b0;
  logic [31:0] ps_in = '0;
  logic        ps_valid_in = 1'b0;

  logic [1:0]  control_out, control_out_u;
  logic [7:0]  a_out, a_out_u, w_out, w_out_u;
  logic        a_valid_out, a_valid_out_u, w_load_out, w_load_out_u;
  logic [31:0] ps_out, ps_out_u;
  logic        ps_valid_out, ps_valid_out_u, shadow_valid, shadow_valid_u;
  logic        ovf_out, ovf_out_u;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  m_active, m_shadow, m_a;
  logic        m_sv, m_avld, m_psvld, m_wload, m_ovf_s, m_ovf_u;
  logic [1:0]  m_ctrl;
  logic [31:0] m_ps_s, m_ps_u;

  always #5 clk = ~clk;

  pe_ws_dbuf #(.WORD_WIDTH(8), .ACC_WIDTH(32), .SIGNED(1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .control_in(control_in), .control_out(control_out),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_out(a_out), .a_valid_out(a_valid_out),
    .w_in(w_in), .w_load_in(w_load_in), .w_out(w_out), .w_load_out(w_load_out),
    .ps_in(ps_in), .ps_valid_in(ps_valid_in), .ps_out(ps_out), .ps_valid_out(ps_valid_out),
    .shadow_valid(shadow_valid), .ovf_out(ovf_out)
  );

  pe_ws_dbuf #(.WORD_WIDTH(8), .ACC_WIDTH(32), .SIGNED(0)) u_dut_u (
    .clk(clk), .reset_n(reset_n),
    .control_in(control_in), .control_out(control_out_u),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_out(a_out_u), .a_valid_out(a_valid_out_u),
    .w_in(w_in), .w_load_in(w_load_in), .w_out(w_out_u), .w_load_out(w_load_out_u),
    .ps_in(ps_in), .ps_valid_in(ps_valid_in), .ps_out(ps_out_u), .ps_valid_out(ps_valid_out_u),
    .shadow_valid(shadow_valid_u), .ovf_out(ovf_out_u)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Exact integer result, then either clamped to the accumulator range or
  // reduced modulo 2^32. Bit 32 of the return value flags a clamp.
  function automatic logic [32:0] ref_mac(input logic [7:0] w, input logic [7:0] a,
                                          input logic [31:0] ps, input bit sgn);
    longint s;
    bit     o;
    o = 1'b0;
    if (sgn) s = longint'($signed(ps)) + longint'($signed(w)) * longint'($signed(a));
    else     s = longint'(ps) + longint'(w) * longint'(a);
`ifdef PE_WS_SATURATE_EN
    if (sgn && s > 64'sd2147483647) begin
      s = 64'sd2147483647; o = 1'b1;
    end else if (sgn && s < -64'sd2147483648) begin
      s = -64'sd2147483648; o = 1'b1;
    end else if (!sgn && s > 64'sd4294967295) begin
      s = 64'sd4294967295; o = 1'b1;
    end
`endif
    return {o, s[31:0]};
  endfunction

  task automatic model_reset();
    m_active = '0; m_shadow = '0; m_a = '0; m_sv = 1'b0;
    m_avld = 1'b0; m_psvld = 1'b0; m_wload = 1'b0;
    m_ovf_s = 1'b0; m_ovf_u = 1'b0; m_ctrl = C_IDLE;
    m_ps_s = '0; m_ps_u = '0;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".ctrl"}, control_out, m_ctrl);
    check_eq({tag, ".a"}, a_out, m_a);
    check_eq({tag, ".av"}, a_valid_out, m_avld);
    check_eq({tag, ".w"}, w_out, m_shadow);
    check_eq({tag, ".wl"}, w_load_out, m_wload);
    check_eq({tag, ".ps"}, ps_out, m_ps_s);
    check_eq({tag, ".psv"}, ps_valid_out, m_psvld);
    check_eq({tag, ".sv"}, shadow_valid, m_sv);
    check_eq({tag, ".ovf"}, ovf_out, m_ovf_s);
    check_eq({tag, ".u_ps"}, ps_out_u, m_ps_u);
    check_eq({tag, ".u_ovf"}, ovf_out_u, m_ovf_u);
    check_eq({tag, ".u_misc"},
             {control_out_u, a_out_u, a_valid_out_u, w_out_u, w_load_out_u, ps_valid_out_u, shadow_valid_u},
             {m_ctrl, m_a, m_avld, m_shadow, m_wload, m_psvld, m_sv});
  endtask

  task automatic step(input logic [1:0] c, input logic [7:0] a, input logic av,
                      input logic [7:0] w, input logic wl, input logic [31:0] ps, input logic pv);
    logic [32:0] rs, ru;
    control_in = c; a_in = a; a_valid_in = av;
    w_in = w; w_load_in = wl; ps_in = ps; ps_valid_in = pv;
    rs = ref_mac(m_active, a, ps, 1'b1);
    ru = ref_mac(m_active, a, ps, 1'b0);
    m_ctrl  = c;
    m_wload = wl;
    case (c)
      C_COMP: begin
        if (av) begin
          m_a = a; m_avld = 1'b1; m_psvld = pv;
          m_ps_s = rs[31:0]; m_ps_u = ru[31:0];
          m_ovf_s = m_ovf_s | rs[32]; m_ovf_u = m_ovf_u | ru[32];
        end else begin
          m_avld = 1'b0; m_psvld = 1'b0;
        end
      end
      C_SWAP: begin
        m_avld = 1'b0; m_psvld = 1'b0;
        if (m_sv) begin
          m_active = m_shadow; m_sv = 1'b0;
        end
      end
      C_CLR: begin
        m_active = '0; m_a = '0; m_ps_s = '0; m_ps_u = '0;
        m_avld = 1'b0; m_psvld = 1'b0; m_ovf_s = 1'b0; m_ovf_u = 1'b0;
        m_shadow = '0; m_sv = 1'b0;
      end
      default: begin
        m_avld = 1'b0; m_psvld = 1'b0;
      end
    endcase
    if (wl) begin
      m_shadow = w; m_sv = 1'b1;
    end
    @(posedge clk);
    #1;
    compare_all("step");
  endtask

  task automatic random_steps(input int n);
    for (int i = 0; i < n; i++) begin
      int unsigned r;
      logic [1:0]  c;
      logic [31:0] ps;
      r = $urandom_range(0, 9);
      c = (r == 0) ? C_CLR : (r <= 2) ? C_SWAP : (r == 3) ? C_IDLE : C_COMP;
      ps = $urandom;
      if ($urandom_range(0, 3) == 0) ps = {ps[31], {27{~ps[31]}}, ps[3:0]};
      step(c, 8'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom),
           1'($urandom_range(0, 2) == 0), ps, 1'($urandom));
    end
  endtask

  initial begin
    model_reset();
    #12;
    compare_all("reset");
    reset_n = 1'b1;

    // Load 3, swap, 10 + 3*5
    step(C_IDLE, 8'd0, 1'b0, 8'd3, 1'b1, 32'd0, 1'b0);
    step(C_SWAP, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    step(C_COMP, 8'd5, 1'b1, 8'd0, 1'b0, 32'd10, 1'b1);
    check_eq("basic_ps", ps_out, 64'd25);
    check_eq("basic_psv", ps_valid_out, 64'd1);
    check_eq("basic_av", a_valid_out, 64'd1);

    // Shadow preload during compute, then swap
    step(C_IDLE, 8'd0, 1'b0, 8'd2, 1'b1, 32'd0, 1'b0);
    step(C_SWAP, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    step(C_COMP, 8'd4, 1'b1, 8'd7, 1'b1, 32'd0, 1'b1);
    check_eq("dbuf_old_ps", ps_out, 64'd8);
    check_eq("dbuf_pending", shadow_valid, 64'd1);
    step(C_SWAP, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    step(C_COMP, 8'd4, 1'b1, 8'd0, 1'b0, 32'd0, 1'b1);
    check_eq("dbuf_new_ps", ps_out, 64'd28);

    // Swap with nothing pending keeps weight 7
    step(C_SWAP, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    step(C_COMP, 8'd4, 1'b1, 8'd0, 1'b0, 32'd0, 1'b1);
    check_eq("empty_swap_ps", ps_out, 64'd28);

    // Weight 0xFD: -3 signed, 253 unsigned
    step(C_IDLE, 8'd0, 1'b0, 8'hFD, 1'b1, 32'd0, 1'b0);
    step(C_SWAP, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    step(C_COMP, 8'd4, 1'b1, 8'd0, 1'b0, 32'd5, 1'b1);
    check_eq("signed_ps", ps_out, 64'hFFFF_FFF9);
    check_eq("unsigned_ps", ps_out_u, 64'd1017);

    // Positive overflow near the accumulator maximum
    step(C_IDLE, 8'd0, 1'b0, 8'd127, 1'b1, 32'd0, 1'b0);
    step(C_SWAP, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    step(C_COMP, 8'd127, 1'b1, 8'd0, 1'b0, 32'h7FFF_FFF0, 1'b1);
`ifdef PE_WS_SATURATE_EN
    check_eq("ovf_ps", ps_out, 64'h7FFF_FFFF);
    check_eq("ovf_flag", ovf_out, 64'd1);
`else
    check_eq("ovf_ps", ps_out, 64'h8000_3EF1);
    check_eq("ovf_flag", ovf_out, 64'd0);
`endif
    step(C_COMP, 8'd1, 1'b1, 8'd0, 1'b0, 32'd0, 1'b1);
    step(C_IDLE, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    step(C_CLR, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    check_eq("clear_ovf", ovf_out, 64'd0);
    check_eq("clear_ps", ps_out, 64'd0);

    // Clear with a same-cycle load keeps the new shadow
    step(C_CLR, 8'd0, 1'b0, 8'h5A, 1'b1, 32'd0, 1'b0);
    check_eq("clear_load_w", w_out, 64'h5A);
    check_eq("clear_load_sv", shadow_valid, 64'd1);

    random_steps(400);

    // Asynchronous reset in the middle of a compute stream
    step(C_IDLE, 8'd0, 1'b0, 8'd9, 1'b1, 32'd0, 1'b0);
    step(C_SWAP, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    step(C_COMP, 8'd10, 1'b1, 8'd6, 1'b1, 32'd1, 1'b1);
    check_eq("pre_rst_ps", ps_out, 64'd91);
    control_in = C_COMP; a_in = 8'd3; a_valid_in = 1'b1; ps_in = 32'd4; ps_valid_in = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    #2;
    reset_n = 1'b1;
    step(C_COMP, 8'd3, 1'b1, 8'd0, 1'b0, 32'd4, 1'b1);
    check_eq("post_rst_ps", ps_out, 64'd4);

    random_steps(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pe_ws_dbuf.md
PE_WS_DBUF -- requirements
Module: pe_ws_dbuf

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, meaning activation/weight width.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, meaning partial-sum width; legal range is >= 2*WORD_WIDTH+1.
REQ-003 SHALL have parameter SIGNED, default 1, meaning 1 = two's-complement operands and accumulate, 0 = unsigned.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have ports control_in (input) and control_out (output), 2 bits each: 00 IDLE, 01 COMPUTE, 10 SWAP, 11 CLEAR; control_out is control_in registered, for the right neighbour.
REQ-007 SHALL have ports a_in (input, WORD_WIDTH) and a_valid_in (input, 1): activation from the left.
REQ-008 SHALL have ports a_out (output, WORD_WIDTH) and a_valid_out (output, 1): activation to the right.
REQ-009 SHALL have ports w_in (input, WORD_WIDTH) and w_load_in (input, 1): shadow-weight chain from above.
REQ-010 SHALL have ports w_out (output, WORD_WIDTH) and w_load_out (output, 1): shadow-weight chain to below.
REQ-011 SHALL have ports ps_in (input, ACC_WIDTH) and ps_valid_in (input, 1): partial sum from above.
REQ-012 SHALL have ports ps_out (output, ACC_WIDTH) and ps_valid_out (output, 1): partial sum to below.
REQ-013 SHALL have outputs shadow_valid (1 bit, shadow weight pending) and ovf_out (1 bit, sticky overflow).

Function
REQ-014 SHALL hold two weight registers: active_w (used by the MAC) and shadow_w (preload).
REQ-015 SHALL, on any cycle with w_load_in=1 and regardless of control_in, load shadow_w<=w_in and set shadow_valid=1.
REQ-016 SHALL register w_out=shadow_w and w_load_out<=w_load_in, giving a 1-cycle-per-row weight shift chain that runs concurrently with COMPUTE.
REQ-017 SHALL, in COMPUTE with a_valid_in=1, register a_out<=a_in, ps_out<=ps_in+active_w*a_in, ps_valid_out<=ps_valid_in, and a_valid_out<=1, with 1-cycle latency.
REQ-018 SHALL, in COMPUTE with a_valid_in=0, drive a_valid_out=0 and ps_valid_out=0 and hold a_out and ps_out.
REQ-019 SHALL, in SWAP with shadow_valid=1, set active_w<=shadow_w and clear shadow_valid; a SWAP with shadow_valid=0 SHALL leave active_w unchanged.
REQ-020 SHALL, for SWAP and w_load_in=1 in the same cycle, move the old shadow_w to active_w, capture the new w_in in shadow_w, and leave shadow_valid=1.
REQ-021 SHALL, in IDLE or SWAP, drive a_valid_out=0 and ps_valid_out=0 and hold the data outputs.
REQ-022 SHALL, in CLEAR, zero active_w, a_out, ps_out, all valids and ovf_out; a same-cycle w_load_in still loads shadow_w, otherwise shadow_w and shadow_valid are cleared.
REQ-023 SHALL form the product at 2*WORD_WIDTH bits, then sign-extend it (SIGNED=1) or zero-extend it (SIGNED=0) to ACC_WIDTH before the add.
REQ-024 SHALL, without saturation, wrap the sum modulo 2^ACC_WIDTH.

Reset
REQ-025 SHALL, on reset_n=0, asynchronously clear active_w, shadow_w, a_out, w_out, ps_out, control_out, all valid and load outputs, shadow_valid and ovf_out to 0.
REQ-026 SHALL, on reset asserted mid-COMPUTE or mid-load, discard the in-flight data; the first result after release requires a fresh load and SWAP.

Configuration
REQ-027 SHALL, with macro PE_WS_SATURATE_EN defined, clamp the sum to the ACC_WIDTH maximum/minimum (unsigned: all-ones/zero) on overflow and set ovf_out, which stays set until CLEAR or reset.
REQ-028 SHALL, without PE_WS_SATURATE_EN, wrap per REQ-024 and tie ovf_out to 0.

Structure
REQ-029 SHALL take the control encodings (IDLE/COMPUTE/SWAP/CLEAR) and default widths from shared package pe_pkg.
REQ-030 SHALL place the combinational multiply, extend and (saturating) add in sub-module pe_mac; all registers stay in pe_ws_dbuf.

Verification
REQ-031 SHALL check: reset then load w_in=3 and SWAP, COMPUTE with a_in=5 and ps_in=10 -> ps_out=25 one cycle later with both valids 1.
REQ-032 SHALL check: active_w=2, shadow load 7 during COMPUTE with a_in=4 and ps_in=0 -> ps_out=8; after SWAP the same input gives ps_out=28.
REQ-033 SHALL check: SWAP with shadow_valid=0 -> active_w unchanged and results match the previous weight.
REQ-034 SHALL check: SIGNED=1, active_w=-3, a_in=4, ps_in=5 -> ps_out=-7; SIGNED=0 with weight 0xFD -> ps_out=1017.
REQ-035 SHALL check, with PE_WS_SATURATE_EN and SIGNED=1: ps_in=0x7FFFFFF0, weight 127, a_in=127 -> ps_out=0x7FFFFFFF and ovf_out=1 until CLEAR; without the macro -> wrapped value and ovf_out=0.
REQ-036 SHALL check: reset_n pulsed low mid-COMPUTE -> all outputs 0 immediately, asynchronously.
